// File: rtl/ami_rcmd_if.sv
// AXI read-address / read-data channel bundle between the command splitter
// (master side) and the AXI master read interface (slave side).
interface ami_rcmd_if #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 40,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_RRESPW = 2
);
  logic [AXI_IW-1:0]     usr_arid;
  logic [AXI_AW-1:0]     usr_araddr;
  logic [AXI_LW-1:0]     usr_arlen;
  logic [AXI_SW-1:0]     usr_arsize;
  logic [1:0]            usr_arburst;
  logic                  usr_arvalid;
  logic                  usr_arready;

  logic [AXI_IW-1:0]     usr_rid;
  logic [AXI_DW-1:0]     usr_rdata;
  logic [AXI_RRESPW-1:0] usr_rresp;
  logic                  usr_rlast;
  logic                  usr_rvalid;
  logic                  usr_rready;

  modport master (
    output usr_arid, usr_araddr, usr_arlen, usr_arsize, usr_arburst, usr_arvalid,
    input  usr_arready,
    input  usr_rid, usr_rdata, usr_rresp, usr_rlast, usr_rvalid,
    output usr_rready
  );

  modport slave (
    input  usr_arid, usr_araddr, usr_arlen, usr_arsize, usr_arburst, usr_arvalid,
    output usr_arready,
    output usr_rid, usr_rdata, usr_rresp, usr_rlast, usr_rvalid,
    input  usr_rready
  );
endinterface

// File: rtl/ami_rcmd.sv
// Read command splitter: takes one (address, beats, id) command, cuts it into
// INCR bursts capped at MAX_BURST beats that never cross a 4 KB page, limits
// the number of bursts in flight, forwards read data and pulses done/done_err
// once every burst of the command has returned its RLAST.
module ami_rcmd #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 40,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_RRESPW = 2,
  parameter int CMD_LW     = 24,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUT    = 4
) (
  input  logic              usr_clk,
  input  logic              usr_reset,
  input  logic [AXI_AW-1:0] cmd_addr,
  input  logic [CMD_LW-1:0] cmd_beats,
  input  logic [AXI_IW-1:0] cmd_id,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  ami_rcmd_if.master        axi,
  output logic [AXI_DW-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              done_err
);

  localparam int BYTES = AXI_DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int OCW   = $clog2(MAX_OUT + 1);
  // Common width wide enough for the remaining count and the 4 KB room (<= 4096).
  localparam int CW    = (CMD_LW > 13) ? CMD_LW : 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [CMD_LW-1:0] rem_q, rem_d;
  logic [AXI_IW-1:0] id_q, id_d;
  logic              err_q, err_d;
  logic [OCW-1:0]    out_cnt_q, out_cnt_d;

  logic [12:0]       bnd_bytes_s;
  logic [12:0]       bnd_beats_s;
  logic [CW-1:0]     rem_x_s;
  logic [CW-1:0]     bnd_x_s;
  logic [CW-1:0]     len_s;
  logic [CW-1:0]     len_m1_s;
  logic [AXI_AW-1:0] inc_s;
  logic              arvalid_s;
  logic              ar_hs_s;
  logic              r_hs_s;
  logic              rlast_hs_s;
  logic              cnt_dec_s;
  logic              unused_s;

  // Beats left before the next 4 KB page; only the low 12 address bits matter.
  assign bnd_bytes_s = 13'h1000 - {1'b0, addr_q[11:0]};
  assign bnd_beats_s = bnd_bytes_s >> BSH;
  assign rem_x_s     = CW'(rem_q);
  assign bnd_x_s     = CW'(bnd_beats_s);
  assign len_m1_s    = len_s - CW'(1);
  assign inc_s       = AXI_AW'(len_s) << BSH;

  // Burst length is the smallest of remaining beats, MAX_BURST and page room.
  always_comb begin
    len_s = rem_x_s;
    if (CW'(MAX_BURST) < len_s) begin
      len_s = CW'(MAX_BURST);
    end else begin
      len_s = len_s;
    end
    if (bnd_x_s < len_s) begin
      len_s = bnd_x_s;
    end else begin
      len_s = len_s;
    end
  end

  assign arvalid_s  = (state_q == ST_ISSUE) && (out_cnt_q < OCW'(MAX_OUT));
  assign ar_hs_s    = arvalid_s & axi.usr_arready;
  assign r_hs_s     = axi.usr_rvalid & out_ready;
  assign rlast_hs_s = r_hs_s & axi.usr_rlast;
  // A stray RLAST with nothing outstanding must not wrap the counter.
  assign cnt_dec_s  = rlast_hs_s && (out_cnt_q != {OCW{1'b0}});

  // Next-state logic for the FSM, the command registers and the in-flight count.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    err_d     = err_q;
    out_cnt_d = out_cnt_q;

    if (ar_hs_s && !cnt_dec_s) begin
      out_cnt_d = out_cnt_q + OCW'(1);
    end else if (!ar_hs_s && cnt_dec_s) begin
      out_cnt_d = out_cnt_q - OCW'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_beats;
          id_d   = cmd_id;
          err_d  = 1'b0;
          if (cmd_beats == {CMD_LW{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_hs_s && (axi.usr_rresp != {AXI_RRESPW{1'b0}})) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (ar_hs_s) begin
          addr_d = addr_q + inc_s;
          rem_d  = rem_q - len_s[CMD_LW-1:0];
          if (rem_q == len_s[CMD_LW-1:0]) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (r_hs_s && (axi.usr_rresp != {AXI_RRESPW{1'b0}})) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (out_cnt_q == {OCW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command registers with synchronous reset.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= {AXI_AW{1'b0}};
      rem_q     <= {CMD_LW{1'b0}};
      id_q      <= {AXI_IW{1'b0}};
      err_q     <= 1'b0;
      out_cnt_q <= {OCW{1'b0}};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      err_q     <= err_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // AR fields come straight from registered state, so they hold while stalled.
  assign axi.usr_arvalid = arvalid_s;
  assign axi.usr_araddr  = addr_q;
  assign axi.usr_arlen   = len_m1_s[AXI_LW-1:0];
  assign axi.usr_arsize  = AXI_SW'(BSH);
  assign axi.usr_arburst = 2'b01;
  assign axi.usr_arid    = id_q;

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign done_err  = (state_q == ST_DONE) & err_q;

  // Data path is a pure pass-through; only LAST is qualified to the final burst.
  assign axi.usr_rready = out_ready;
  assign out_valid      = axi.usr_rvalid;
  assign out_data       = axi.usr_rdata;
  assign out_last       = axi.usr_rlast & (rem_q == {CMD_LW{1'b0}}) &
                          (out_cnt_q == OCW'(1));

  assign unused_s = ^{axi.usr_rid, len_m1_s[CW-1:AXI_LW]};

endmodule
